// File: rtl/fp_addsub_issuer.sv
// Issue/return controller for a shared FP add/sub unit: credit-limited request issue,
// in-order result FIFO. Optional tag cross-check enabled by defining FP_ADDSUB_TAG_CHECK_EN.
module fp_addsub_issuer #(
  parameter int unsigned FP_WIDTH   = 32,
  parameter int unsigned TAG_WIDTH  = 5,
  parameter int unsigned RND_WIDTH  = 3,
  parameter int unsigned STAT_WIDTH = 8,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         req_valid_i,
  output logic                         req_ready_o,
  input  logic                         req_sub_i,
  input  logic [FP_WIDTH-1:0]          req_opa_i,
  input  logic [FP_WIDTH-1:0]          req_opb_i,
  input  logic [TAG_WIDTH-1:0]         req_tag_i,
  input  logic [RND_WIDTH-1:0]         req_rnd_i,
  output logic                         En_o,
  output logic                         SubSel_o,
  output logic [FP_WIDTH-1:0]          OpA_o,
  output logic [FP_WIDTH-1:0]          OpB_o,
  output logic [TAG_WIDTH-1:0]         Tag_o,
  output logic [RND_WIDTH-1:0]         Rnd_o,
  input  logic                         Ready_i,
  input  logic                         Valid_i,
  input  logic [FP_WIDTH-1:0]          Res_i,
  input  logic [TAG_WIDTH-1:0]         Tag_i,
  input  logic [STAT_WIDTH-1:0]        Status_i,
  output logic                         rsp_valid_o,
  input  logic                         rsp_ready_i,
  output logic [FP_WIDTH-1:0]          rsp_res_o,
  output logic [TAG_WIDTH-1:0]         rsp_tag_o,
  output logic [STAT_WIDTH-1:0]        rsp_status_o,
  output logic [$clog2(DEPTH):0]       inflight_o,
  output logic [1:0]                   err_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  typedef struct packed {
    logic [FP_WIDTH-1:0]   res;
    logic [TAG_WIDTH-1:0]  tag;
    logic [STAT_WIDTH-1:0] status;
  } result_t;

  logic             req_hs;
  logic             rsp_hs;
  logic [CNT_W-1:0] reserved_q, reserved_d;

  // Credits are taken from the registered count only, so rsp_ready_i never reaches req_ready_o.
  assign req_ready_o = Ready_i && (reserved_q < DEPTH_C);
  assign req_hs      = req_valid_i && req_ready_o;
  assign rsp_hs      = rsp_valid_o && rsp_ready_i;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    reserved_d = reserved_q;
    if (req_hs && !rsp_hs)      reserved_d = reserved_q + CNT_ONE;
    else if (!req_hs && rsp_hs) reserved_d = reserved_q - CNT_ONE;
  end

  logic                 en_q, sub_q;
  logic [FP_WIDTH-1:0]  opa_q, opb_q;
  logic [TAG_WIDTH-1:0] tag_q;
  logic [RND_WIDTH-1:0] rnd_q;

  // NOTE: sequential state uses non-blocking (<=) so all registers update from pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      reserved_q <= '0;
      en_q       <= 1'b0;
      sub_q      <= 1'b0;
      opa_q      <= '0;
      opb_q      <= '0;
      tag_q      <= '0;
      rnd_q      <= '0;
    end else begin
      reserved_q <= reserved_d;
      en_q       <= req_hs;
      if (req_hs) begin
        sub_q <= req_sub_i;
        opa_q <= req_opa_i;
        opb_q <= req_opb_i;
        tag_q <= req_tag_i;
        rnd_q <= req_rnd_i;
      end
    end
  end

  assign En_o     = en_q;
  assign SubSel_o = sub_q;
  assign OpA_o    = opa_q;
  assign OpB_o    = opb_q;
  assign Tag_o    = tag_q;
  assign Rnd_o    = rnd_q;

  result_t          mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             fifo_full, fifo_empty, wr_en, overflow;

  assign fifo_full  = (count_q == DEPTH_C);
  assign fifo_empty = (count_q == '0);
  // A pop in the same cycle frees the head slot, so a full FIFO can still accept the write.
  assign wr_en      = Valid_i && (!fifo_full || rsp_hs);
  assign overflow   = Valid_i && fifo_full && !rsp_hs;

  // NOTE: the storage array is reset too, so the show-ahead response data reads 0 after reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) begin
        mem_q[wr_ptr_q] <= '{res: Res_i, tag: Tag_i, status: Status_i};
        wr_ptr_q        <= wr_ptr_q + PTR_ONE;
      end
      if (rsp_hs) rd_ptr_q <= rd_ptr_q + PTR_ONE;
      if (wr_en && !rsp_hs)      count_q <= count_q + CNT_ONE;
      else if (!wr_en && rsp_hs) count_q <= count_q - CNT_ONE;
    end
  end

  assign rsp_valid_o  = !fifo_empty;
  assign rsp_res_o    = mem_q[rd_ptr_q].res;
  assign rsp_tag_o    = mem_q[rd_ptr_q].tag;
  assign rsp_status_o = mem_q[rd_ptr_q].status;
  assign inflight_o   = reserved_q;

  logic tag_mismatch;

`ifdef FP_ADDSUB_TAG_CHECK_EN
  logic [TAG_WIDTH-1:0] tag_mem_q [DEPTH];
  logic [PTR_W-1:0]     tag_wr_q, tag_rd_q;
  logic [CNT_W-1:0]     tag_cnt_q;
  logic                 tag_push, tag_pop;

  // Tags are recorded at handshake so a zero-latency unit result can be matched in the issue cycle.
  assign tag_pop      = Valid_i && (tag_cnt_q != '0);
  assign tag_push     = req_hs && ((tag_cnt_q != DEPTH_C) || tag_pop);
  assign tag_mismatch = tag_pop && (Tag_i != tag_mem_q[tag_rd_q]);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) tag_mem_q[i] <= '0;
      tag_wr_q  <= '0;
      tag_rd_q  <= '0;
      tag_cnt_q <= '0;
    end else begin
      if (tag_push) begin
        tag_mem_q[tag_wr_q] <= req_tag_i;
        tag_wr_q            <= tag_wr_q + PTR_ONE;
      end
      if (tag_pop) tag_rd_q <= tag_rd_q + PTR_ONE;
      if (tag_push && !tag_pop)      tag_cnt_q <= tag_cnt_q + CNT_ONE;
      else if (!tag_push && tag_pop) tag_cnt_q <= tag_cnt_q - CNT_ONE;
    end
  end
`else
  assign tag_mismatch = 1'b0;
`endif

  logic [1:0] err_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q <= '0;
    end else begin
      if (overflow)     err_q[0] <= 1'b1;
      if (tag_mismatch) err_q[1] <= 1'b1;
    end
  end

  assign err_o = err_q;

endmodule

// File: tb/tb_fp_addsub_issuer.sv
// Scoreboard bench for fp_addsub_issuer with a zero-pipe behavioural add/sub unit.
module tb_fp_addsub_issuer;

  localparam int FPW = 32, TW = 5, RW = 3, SW = 8, DEPTH = 4;
`ifdef FP_ADDSUB_TAG_CHECK_EN
  localparam logic TAG_ERR_EXP = 1'b1;
`else
  localparam logic TAG_ERR_EXP = 1'b0;
`endif

  logic           clk_i = 1'b0;
  logic           rst_ni = 1'b0;
  logic           req_valid_i = 1'b0, req_ready_o, req_sub_i = 1'b0;
  logic [FPW-1:0] req_opa_i = '0, req_opb_i = '0;
  logic [TW-1:0]  req_tag_i = '0;
  logic [RW-1:0]  req_rnd_i = '0;
  logic           En_o, SubSel_o;
  logic [FPW-1:0] OpA_o, OpB_o;
  logic [TW-1:0]  Tag_o;
  logic [RW-1:0]  Rnd_o;
  logic           Ready_i, Valid_i;
  logic [FPW-1:0] Res_i;
  logic [TW-1:0]  Tag_i;
  logic [SW-1:0]  Status_i;
  logic           rsp_valid_o, rsp_ready_i = 1'b0;
  logic [FPW-1:0] rsp_res_o;
  logic [TW-1:0]  rsp_tag_o;
  logic [SW-1:0]  rsp_status_o;
  logic [2:0]     inflight_o;
  logic [1:0]     err_o;

  fp_addsub_issuer #(.FP_WIDTH(FPW), .TAG_WIDTH(TW), .RND_WIDTH(RW), .STAT_WIDTH(SW), .DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_sub_i(req_sub_i),
    .req_opa_i(req_opa_i), .req_opb_i(req_opb_i), .req_tag_i(req_tag_i), .req_rnd_i(req_rnd_i),
    .En_o(En_o), .SubSel_o(SubSel_o), .OpA_o(OpA_o), .OpB_o(OpB_o), .Tag_o(Tag_o), .Rnd_o(Rnd_o),
    .Ready_i(Ready_i), .Valid_i(Valid_i), .Res_i(Res_i), .Tag_i(Tag_i), .Status_i(Status_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_res_o(rsp_res_o),
    .rsp_tag_o(rsp_tag_o), .rsp_status_o(rsp_status_o), .inflight_o(inflight_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  // Behavioural unit: known FP vectors by table, anything else integer add/sub as a stand-in.
  function automatic logic [FPW-1:0] unit_fn(input logic sub, input logic [FPW-1:0] a, input logic [FPW-1:0] b);
    if (!sub && a == 32'h3F80_0000 && b == 32'h4000_0000) return 32'h4040_0000;
    if (sub && a == 32'h4040_0000 && b == 32'h3F80_0000)  return 32'h4000_0000;
    return sub ? a - b : a + b;
  endfunction

  logic           unit_ready = 1'b1, force_valid = 1'b0, tag_ovr_en = 1'b0;
  logic [TW-1:0]  tag_ovr = '0;
  logic [FPW-1:0] force_res = '0;

  assign Ready_i  = unit_ready;
  assign Valid_i  = En_o | force_valid;
  assign Res_i    = force_valid ? force_res : unit_fn(SubSel_o, OpA_o, OpB_o);
  assign Tag_i    = tag_ovr_en ? tag_ovr : Tag_o;
  assign Status_i = Res_i[7:0] ^ 8'hA5;

  typedef struct packed {
    logic           sub;
    logic [FPW-1:0] a;
    logic [FPW-1:0] b;
    logic [TW-1:0]  tag;
    logic [RW-1:0]  rnd;
  } iss_t;
  typedef struct packed {
    logic [FPW-1:0] res;
    logic [TW-1:0]  tag;
    logic [SW-1:0]  st;
  } rsp_t;

  iss_t iss_q[$];
  rsp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: bound expired or unexpected event", name);
  endtask

  // Monitor: issue strobes and response handshakes are popped against the queues.
  always @(negedge clk_i) begin
    iss_t ei;
    rsp_t er;
    if (rst_ni) begin
      if (En_o) begin
        if (iss_q.size() == 0) flag("issue_unexpected");
        else begin
          ei = iss_q.pop_front();
          check("issue", {SubSel_o, OpA_o, OpB_o, Tag_o, Rnd_o}, ei);
        end
      end
      if (rsp_valid_o && rsp_ready_i) begin
        if (exp_q.size() == 0) flag("rsp_unexpected");
        else begin
          er = exp_q.pop_front();
          check("rsp", {rsp_res_o, rsp_tag_o, rsp_status_o}, er);
        end
      end
    end
  end

  task automatic send(input logic sub, input logic [FPW-1:0] a, input logic [FPW-1:0] b,
                      input logic [TW-1:0] tag, input logic [RW-1:0] rnd,
                      input logic [TW-1:0] rtag, output int stalls);
    logic [FPW-1:0] r;
    r = unit_fn(sub, a, b);
    stalls = 0;
    req_valid_i = 1'b1;
    req_sub_i = sub; req_opa_i = a; req_opb_i = b; req_tag_i = tag; req_rnd_i = rnd;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk_i);
      if (req_ready_o) begin
        iss_q.push_back(iss_t'{sub, a, b, tag, rnd});
        exp_q.push_back(rsp_t'{r, rtag, r[7:0] ^ 8'hA5});
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        return;
      end
      stalls++;
    end
    flag("send_timeout");
    req_valid_i = 1'b0;
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 100; k++) begin
      @(posedge clk_i); #2;
      if (exp_q.size() == 0) break;
    end
    check("drain_remaining", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    iss_q.delete();
    exp_q.delete();
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
  endtask

  int st, stall_sum;

  initial begin
    // Reset state
    #12;
    check("rst_en", En_o, 0);
    check("rst_rsp_valid", rsp_valid_o, 0);
    check("rst_inflight", inflight_o, 0);
    check("rst_err", err_o, 0);
    check("rst_rsp_data", {rsp_res_o, rsp_tag_o, rsp_status_o}, 0);
    check("rst_issue_data", {SubSel_o, OpA_o, OpB_o, Tag_o, Rnd_o}, 0);
    check("rst_ready_follows_unit", req_ready_o, 1);
    unit_ready = 1'b0; #1;
    check("rst_ready_unit_low", req_ready_o, 0);
    unit_ready = 1'b1;
    @(posedge clk_i); #1;
    rst_ni = 1'b1;

    // 1: add path and latency
    rsp_ready_i = 1'b1;
    send(1'b0, 32'h3F80_0000, 32'h4000_0000, 5'd3, 3'd0, 5'd3, st);
    check("t1_en_n1", En_o, 1);
    check("t1_rsp_not_n1", rsp_valid_o, 0);
    @(posedge clk_i); #1;
    check("t1_rsp_valid_n2", rsp_valid_o, 1);
    check("t1_res", rsp_res_o, 32'h4040_0000);
    check("t1_tag", rsp_tag_o, 3);
    wait_drain();

    // 2: subtract path
    send(1'b1, 32'h4040_0000, 32'h3F80_0000, 5'd7, 3'd2, 5'd7, st);
    @(posedge clk_i); #1;
    check("t2_res", rsp_res_o, 32'h4000_0000);
    check("t2_tag", rsp_tag_o, 7);
    wait_drain();

    // 3: credit exhaustion, no same-cycle ready from a pop
    rsp_ready_i = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      send(1'b0, 32'(i), 32'd10, 5'(i), 3'(i), 5'(i), st);
    check("t3_ready_low", req_ready_o, 0);
    check("t3_inflight_full", inflight_o, 4);
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    rsp_ready_i = 1'b1; #1;
    check("t3_no_comb_ready", req_ready_o, 0);
    @(posedge clk_i); #1;
    rsp_ready_i = 1'b0;
    check("t3_ready_back", req_ready_o, 1);
    check("t3_inflight_3", inflight_o, 3);
    rsp_ready_i = 1'b1;
    wait_drain();
    check("t3_inflight_0", inflight_o, 0);

    // 4: full throughput
    stall_sum = 0;
    for (int i = 0; i < 16; i++) begin
      send(1'(i % 2), 32'h1000 + 32'(i), 32'(i), 5'(i + 8), 3'(i % 8), 5'(i + 8), st);
      stall_sum += st;
    end
    check("t4_stalls", stall_sum, 0);
    wait_drain();
    check("t4_err", err_o, 0);

    // 5: unexpected Valid_i while full
    rsp_ready_i = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      send(1'b1, 32'h500 + 32'(i), 32'd1, 5'(20 + i), 3'd1, 5'(20 + i), st);
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    force_res = 32'hDEAD_BEEF;
    force_valid = 1'b1;
    @(posedge clk_i); #1;
    force_valid = 1'b0;
    check("t5_overflow_err", err_o[0], 1);
    rsp_ready_i = 1'b1;
    wait_drain();
    @(posedge clk_i); #2;
    check("t5_dropped_write", rsp_valid_o, 0);
    check("t5_err_sticky", err_o[0], 1);
    do_reset();
    check("t5_err_cleared", err_o, 0);

    // 6: tag mismatch, then reset mid-burst
    tag_ovr = 5'd5;
    tag_ovr_en = 1'b1;
    send(1'b0, 32'h40, 32'h2, 5'd2, 3'd3, 5'd5, st);
    @(posedge clk_i); #1;
    tag_ovr_en = 1'b0;
    check("t6_tag_err", err_o[1], TAG_ERR_EXP);
    check("t6_no_overflow_err", err_o[0], 0);
    wait_drain();

    rsp_ready_i = 1'b0;
    for (int i = 0; i < 3; i++)
      send(1'b0, 32'h77, 32'(i), 5'(i), 3'd0, 5'(i), st);
    #2;
    rst_ni = 1'b0;
    iss_q.delete();
    exp_q.delete();
    #1;
    check("t6_rst_async_outputs", {En_o, rsp_valid_o, inflight_o, err_o}, 0);
    @(posedge clk_i); #1;
    check("t6_rst_next_cycle", {En_o, rsp_valid_o, inflight_o, err_o, OpA_o, rsp_res_o}, 0);
    rst_ni = 1'b1;
    rsp_ready_i = 1'b1;
    send(1'b1, 32'h4040_0000, 32'h3F80_0000, 5'd9, 3'd4, 5'd9, st);
    wait_drain();

    check("end_issue_queue", iss_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fp_addsub_issuer.md
Name: fp_addsub_issuer

Overview:
Initiator-side controller for the shared-APU FP add/sub unit. Accepts add/sub requests from a requester over a valid/ready interface and issues them to the unit via its En/SubSel/OpA/OpB/Tag/Rnd inputs. Captures the unit's Valid/Res/Tag/Status results, which have no backpressure, into a credit-protected result FIFO. Returns results in order over a valid/ready response interface.

Parameters:
FP_WIDTH, 32, operand/result width
TAG_WIDTH, 5, request tag width
RND_WIDTH, 3, rounding-mode width
STAT_WIDTH, 8, unit status flag width
DEPTH, 4, result FIFO entries = maximum requests in flight plus buffered (power of 2, >=2)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
req_valid_i  in  1  request valid
req_ready_o  out  1  request accepted this cycle when high with req_valid_i
req_sub_i  in  1  1=subtract, 0=add
req_opa_i / req_opb_i  in  FP_WIDTH  operands
req_tag_i  in  TAG_WIDTH  request tag
req_rnd_i  in  RND_WIDTH  rounding mode
En_o  out  1  issue strobe to unit
SubSel_o  out  1  to unit
OpA_o / OpB_o  out  FP_WIDTH  to unit
Tag_o  out  TAG_WIDTH  to unit
Rnd_o  out  RND_WIDTH  to unit
Ready_i  in  1  unit ready
Valid_i  in  1  unit result valid
Res_i  in  FP_WIDTH  unit result
Tag_i  in  TAG_WIDTH  unit result tag
Status_i  in  STAT_WIDTH  unit status
rsp_valid_o  out  1  response valid
rsp_ready_i  in  1  response consumed
rsp_res_o  out  FP_WIDTH  result
rsp_tag_o  out  TAG_WIDTH  tag
rsp_status_o  out  STAT_WIDTH  status
inflight_o  out  log2(DEPTH)+1  reserved-credit count
err_o  out  2  sticky errors: [0] overflow, [1] tag mismatch

Behaviour:
- Clock is clk_i. Reset is asynchronous, active-low on rst_ni.
- Reset state: all registers 0. En_o, SubSel_o, OpA_o, OpB_o, Tag_o, Rnd_o, rsp_valid_o, inflight_o and err_o read 0. rsp_* data reads 0. req_ready_o = Ready_i.
- Credit counter `reserved` (0..DEPTH), driven onto inflight_o:
  - Increments on request handshake.
  - Decrements on response handshake (rsp_valid_o & rsp_ready_i).
  - Both in the same cycle: unchanged.
- req_ready_o = Ready_i & (reserved < DEPTH). There is no combinational path from rsp_ready_i. At reserved==DEPTH, a pop in the same cycle does not raise ready.
- Issue stage is registered. On a request handshake in cycle N:
  - En_o=1 in N+1.
  - SubSel_o/OpA_o/OpB_o/Tag_o/Rnd_o carry the request in N+1.
- Otherwise En_o=0 and the data outputs hold their last value.
- Result capture: Valid_i=1 writes {Res_i, Tag_i, Status_i} at the FIFO tail.
  - Valid_i while the FIFO is full is impossible by credit construction.
  - If it does occur: drop the write, set err_o[0] (sticky until reset).
- Simultaneous Valid_i write and response pop is allowed at any occupancy, including full (pop frees the slot first).
- Response: rsp_valid_o = FIFO not empty. rsp_* shows the head entry (show-ahead) and holds stable while rsp_valid_o & !rsp_ready_i.
- Latency with a zero-pipe unit: request handshake N -> En_o N+1 -> Valid_i N+1 -> rsp_valid_o N+2. With C pipe regs in the unit: N+2+C.
- Throughput: 1 request/cycle while credits remain and rsp_ready_i=1.
- Pointers wrap modulo DEPTH. Occupancy counter is log2(DEPTH)+1 bits.
- Reset mid-operation: in-flight and buffered results are discarded, counters cleared. The unit is reset on the same rst_ni.

Optional Feature:
FP_ADDSUB_TAG_CHECK_EN:
- When defined: a DEPTH-entry tag FIFO records Tag_o on each issue and pops on each Valid_i. If Tag_i != popped tag, set err_o[1] (sticky). The result is still written.
- When undefined: no tag FIFO, and err_o[1] is tied 0.

Test Plan:
1. Add path: reset, then request add A=0x3F800000, B=0x40000000, tag=3, rnd=0 -> En_o one cycle later; rsp_res_o=0x40400000, rsp_tag_o=3, rsp_valid_o exactly 2 cycles after handshake (zero-pipe unit).
2. Subtract path: sub A=0x40400000, B=0x3F800000, tag=7 -> rsp_res_o=0x40000000, rsp_tag_o=7.
3. Credit exhaustion: hold rsp_ready_i=0, issue DEPTH=4 back-to-back requests -> req_ready_o=0 after the 4th, inflight_o=4. Raise rsp_ready_i for 1 cycle -> ready returns the next cycle, not the same cycle. Responses are in order, tags 0,1,2,3.
4. Full throughput: rsp_ready_i=1, 16 consecutive requests -> req_ready_o stays 1, 16 responses in order, err_o=0.
5. Unexpected Valid_i: force Valid_i while the FIFO is full -> write dropped, err_o[0]=1 until reset.
6. With FP_ADDSUB_TAG_CHECK_EN: return tag 5 for an issued tag 2 -> err_o[1]=1. Without the macro: err_o[1]=0. Reset mid-burst -> all outputs 0 and inflight_o=0 next cycle.
